peer_link: RTL and testbench

Inter-board link front end between the three peer wires (`receive_connect`, `receive_start`, `receive_game_finish` / `send_*`) and the game stage controller.

- Synchronizes and glitch-filters the asynchronous inputs arriving from the peer FPGA.
- Turns the filtered start and finish levels into clean edge pulses.
- Drives a heartbeat on `send_connect` while a connection is requested.
- Runs a watchdog that decides whether the peer is present.

The stage controller consumes `peer_present` and the pulses in place of the raw pins.

---
 rtl/peer_link.sv | 204 ++++++++++++++++++++
 tb/tb_peer_link.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/peer_link.sv
// Inter-board link front end: synchronizes and filters the three peer wires,
// derives edge pulses, drives the connect heartbeat and tracks peer presence.
module peer_link #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_CYCLES  = 16,
  parameter int HB_HALF        = 50_000,
  parameter int TIMEOUT_CYCLES = 200_000
) (
  input  logic clk,
  input  logic rst,
  input  logic local_connect,
  input  logic local_start,
  input  logic local_finish,
  input  logic receive_connect,
  input  logic receive_start,
  input  logic receive_game_finish,
  output logic send_connect,
  output logic send_start,
  output logic send_game_finish,
  output logic peer_present,
  output logic peer_lost,
  output logic peer_start,
  output logic peer_start_rise,
  output logic peer_finish,
  output logic peer_finish_rise
);

  localparam int FC_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam int HB_W = (HB_HALF > 1) ? $clog2(HB_HALF) : 1;
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILTER_CYCLES - 1);
  localparam logic [HB_W-1:0] HB_LAST = HB_W'(HB_HALF - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [FC_W-1:0] FC_ZERO = {FC_W{1'b0}};
  localparam logic [HB_W-1:0] HB_ZERO = {HB_W{1'b0}};
  localparam logic [TO_W-1:0] TO_ZERO = {TO_W{1'b0}};

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } wd_state_e;

  // Channel index: 0 = connect, 1 = start, 2 = finish.
  logic [2:0]             raw_s;
  logic [SYNC_STAGES-1:0] sync_r [3];
  logic [2:0]             sync_s;
  logic [FC_W-1:0]        cnt_r [3];
  logic [FC_W-1:0]        cnt_nx_s [3];
  logic [2:0]             flt_r;
  logic [2:0]             flt_nx_s;
  logic [1:0]             rise_r;
  logic                   hb_edge_r;

  logic [HB_W-1:0]        hb_cnt_r;
  logic                   send_connect_r;
  logic                   send_start_r;
  logic                   send_game_finish_r;

  wd_state_e              state_r;
  wd_state_e              state_nx_s;
  logic [TO_W-1:0]        t_r;
  logic [TO_W-1:0]        t_nx_s;
  logic                   lost_nx_s;
  logic                   peer_present_r;
  logic                   peer_lost_r;

  assign raw_s = {receive_game_finish, receive_start, receive_connect};

  // Select the last stage of each synchronizer chain.
  always_comb begin
    sync_s = 3'b000;
    for (int i = 0; i < 3; i++) begin
      sync_s[i] = sync_r[i][SYNC_STAGES-1];
    end
  end

  // Stability filter: the level only follows after FILTER_CYCLES agreeing samples.
  always_comb begin
    flt_nx_s = flt_r;
    for (int i = 0; i < 3; i++) begin
      cnt_nx_s[i] = FC_ZERO;
      if (sync_s[i] == flt_r[i]) begin
        cnt_nx_s[i] = FC_ZERO;
      end else if (cnt_r[i] == FC_LAST) begin
        flt_nx_s[i] = sync_s[i];
        cnt_nx_s[i] = FC_ZERO;
      end else begin
        cnt_nx_s[i] = cnt_r[i] + FC_W'(1);
      end
    end
  end

  // Synchronizer chains, filter state and edge strobes coincident with the level change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        sync_r[i] <= {SYNC_STAGES{1'b0}};
        cnt_r[i]  <= FC_ZERO;
      end
      flt_r     <= 3'b000;
      rise_r    <= 2'b00;
      hb_edge_r <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        sync_r[i] <= {sync_r[i][SYNC_STAGES-2:0], raw_s[i]};
        cnt_r[i]  <= cnt_nx_s[i];
      end
      flt_r     <= flt_nx_s;
      rise_r    <= flt_nx_s[2:1] & ~flt_r[2:1];
      hb_edge_r <= flt_nx_s[0] ^ flt_r[0];
    end
  end

  // Heartbeat square wave, parked low while no connection is requested.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hb_cnt_r       <= HB_ZERO;
      send_connect_r <= 1'b0;
    end else if (!local_connect) begin
      hb_cnt_r       <= HB_ZERO;
      send_connect_r <= 1'b0;
    end else if (hb_cnt_r == HB_LAST) begin
      hb_cnt_r       <= HB_ZERO;
      send_connect_r <= ~send_connect_r;
    end else begin
      hb_cnt_r       <= hb_cnt_r + HB_W'(1);
      send_connect_r <= send_connect_r;
    end
  end

  // One-stage mirrors of the local levels toward the peer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      send_start_r       <= 1'b0;
      send_game_finish_r <= 1'b0;
    end else begin
      send_start_r       <= local_start;
      send_game_finish_r <= local_finish;
    end
  end

  // Watchdog state and timer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      t_r     <= TO_ZERO;
    end else begin
      state_r <= state_nx_s;
      t_r     <= t_nx_s;
    end
  end

  // Watchdog next state; a heartbeat edge on the timeout cycle keeps the peer present.
  always_comb begin
    state_nx_s = state_r;
    t_nx_s     = TO_ZERO;
    lost_nx_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (hb_edge_r) begin
          state_nx_s = ST_PRESENT;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_PRESENT: begin
        if (hb_edge_r) begin
          t_nx_s = TO_ZERO;
        end else if (t_r == TO_LAST) begin
          state_nx_s = ST_IDLE;
          lost_nx_s  = 1'b1;
        end else begin
          t_nx_s = t_r + TO_W'(1);
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Watchdog outputs, registered so they change on the same edge as the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peer_present_r <= 1'b0;
      peer_lost_r    <= 1'b0;
    end else begin
      peer_present_r <= (state_nx_s == ST_PRESENT);
      peer_lost_r    <= lost_nx_s;
    end
  end

  assign send_connect     = send_connect_r;
  assign send_start       = send_start_r;
  assign send_game_finish = send_game_finish_r;
  assign peer_present     = peer_present_r;
  assign peer_lost        = peer_lost_r;
  assign peer_start       = flt_r[1];
  assign peer_start_rise  = rise_r[0];
  assign peer_finish      = flt_r[2];
  assign peer_finish_rise = rise_r[1];

endmodule

// File: tb/tb_peer_link.sv
// Directed bench for peer_link: filtering, heartbeat, loopback, watchdog timing and reset.
module tb_peer_link;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic local_connect = 1'b0;
  logic local_start = 1'b0;
  logic local_finish = 1'b0;
  logic rc_drv = 1'b0;
  logic loop_en = 1'b0;
  logic receive_start = 1'b0;
  logic receive_game_finish = 1'b0;
  logic rc_s;
  logic send_connect, send_start, send_game_finish;
  logic peer_present, peer_lost, peer_start, peer_start_rise, peer_finish, peer_finish_rise;

  int n_checks = 0;
  int n_errors = 0;
  int rise_s_cnt = 0;
  int rise_f_cnt = 0;
  int lost_cnt = 0;

  assign rc_s = loop_en ? send_connect : rc_drv;

  peer_link #(
    .SYNC_STAGES(2), .FILTER_CYCLES(4), .HB_HALF(8), .TIMEOUT_CYCLES(40)
  ) dut (
    .clk(clk), .rst(rst),
    .local_connect(local_connect), .local_start(local_start), .local_finish(local_finish),
    .receive_connect(rc_s), .receive_start(receive_start),
    .receive_game_finish(receive_game_finish),
    .send_connect(send_connect), .send_start(send_start), .send_game_finish(send_game_finish),
    .peer_present(peer_present), .peer_lost(peer_lost),
    .peer_start(peer_start), .peer_start_rise(peer_start_rise),
    .peer_finish(peer_finish), .peer_finish_rise(peer_finish_rise)
  );

  always #5 clk = ~clk;

  // Pulse tallies, sampled mid-cycle.
  always @(negedge clk) begin
    if (peer_start_rise) rise_s_cnt++;
    if (peer_finish_rise) rise_f_cnt++;
    if (peer_lost) lost_cnt++;
  end

  function automatic logic [8:0] all_outs();
    return {send_connect, send_start, send_game_finish, peer_present, peer_lost,
            peer_start, peer_start_rise, peer_finish, peer_finish_rise};
  endfunction

  function automatic logic sig(input int sel);
    case (sel)
      0: return peer_start;
      1: return peer_finish;
      2: return send_connect;
      3: return peer_present;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks until sig(sel)==val; n is the tick count or -1 if the bound expires.
  task automatic wait_until(input int sel, input logic val, input int bound, output int n);
    n = -1;
    for (int k = 1; k <= bound; k++) begin
      tick();
      if (sig(sel) == val) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int base;
    logic pres_seen;

    repeat (3) tick();
    check("reset_outs", 32'(all_outs()), 32'd0);
    rst = 1'b0;
    repeat (2) tick();

    // 3-cycle glitch on start must be rejected.
    base = rise_s_cnt;
    receive_start = 1'b1;
    repeat (3) tick();
    receive_start = 1'b0;
    repeat (10) tick();
    check("glitch_level", 32'(peer_start), 32'd0);
    check("glitch_rise_cnt", 32'(rise_s_cnt - base), 32'd0);

    receive_start = 1'b1;
    wait_until(0, 1'b1, 20, n);
    check("start_latency", n, 6);
    check("start_rise_same_cycle", 32'(peer_start_rise), 32'd1);
    repeat (10) tick();
    check("start_rise_cnt", 32'(rise_s_cnt - base), 32'd1);

    // Finish path: rise then fall, only one rise pulse.
    base = rise_f_cnt;
    receive_game_finish = 1'b1;
    wait_until(1, 1'b1, 20, n);
    check("finish_latency", n, 6);
    check("finish_rise_same_cycle", 32'(peer_finish_rise), 32'd1);
    receive_game_finish = 1'b0;
    wait_until(1, 1'b0, 20, n);
    check("finish_fall_latency", n, 6);
    check("finish_fall_no_rise", 32'(peer_finish_rise), 32'd0);
    repeat (2) tick();
    check("finish_rise_cnt", 32'(rise_f_cnt - base), 32'd1);

    // Send mirrors: one register of delay.
    local_start = 1'b1;
    local_finish = 1'b1;
    check("mirror_start_pre", 32'(send_start), 32'd0);
    check("mirror_finish_pre", 32'(send_game_finish), 32'd0);
    tick();
    check("mirror_start", 32'(send_start), 32'd1);
    check("mirror_finish", 32'(send_game_finish), 32'd1);

    // Heartbeat period.
    local_connect = 1'b1;
    wait_until(2, 1'b1, 20, n);
    check("hb_first_toggle", n, 8);
    wait_until(2, 1'b0, 20, n);
    check("hb_second_toggle", n, 8);
    wait_until(2, 1'b1, 20, n);
    check("hb_third_toggle", n, 8);
    local_connect = 1'b0;
    tick();
    check("hb_off", 32'(send_connect), 32'd0);

    // Loopback presence.
    loop_en = 1'b1;
    local_connect = 1'b1;
    wait_until(3, 1'b1, 40, n);
    check("loop_present_latency", n, 15);
    base = lost_cnt;
    repeat (1000) tick();
    check("loop_present_hold", 32'(peer_present), 32'd1);
    check("loop_no_lost", 32'(lost_cnt - base), 32'd0);

    // Freeze the peer wire and let the watchdog expire.
    rc_drv = send_connect;
    loop_en = 1'b0;
    local_connect = 1'b0;
    wait_until(3, 1'b0, 100, n);
    check("freeze_timeout", 32'((n >= 30) && (n <= 48)), 32'd1);
    check("freeze_lost_with_fall", 32'(peer_lost), 32'd1);
    tick();
    check("lost_one_cycle", 32'(peer_lost), 32'd0);

    // Single controlled edge: PRESENT lasts exactly 40 cycles.
    rc_drv = ~rc_drv;
    wait_until(3, 1'b1, 20, n);
    check("edge_to_present", n, 7);
    base = lost_cnt;
    wait_until(3, 1'b0, 60, n);
    check("timeout_exact", n, 40);
    check("timeout_lost", 32'(peer_lost), 32'd1);
    tick();
    check("timeout_lost_cnt", 32'(lost_cnt - base), 32'd1);

    // Edge landing on t=39 keeps PRESENT.
    rc_drv = ~rc_drv;
    wait_until(3, 1'b1, 20, n);
    check("edge2_to_present", n, 7);
    base = lost_cnt;
    repeat (33) tick();
    rc_drv = ~rc_drv;
    repeat (6) tick();
    check("at_t39_present", 32'(peer_present), 32'd1);
    tick();
    check("edge_wins_present", 32'(peer_present), 32'd1);
    check("edge_wins_no_lost", 32'(peer_lost), 32'd0);
    wait_until(3, 1'b0, 60, n);
    check("edge_wins_restart", n, 40);
    tick();
    check("edge_wins_lost_cnt", 32'(lost_cnt - base), 32'd1);

    // Reach PRESENT with the peer wire resting low, then reset mid-run.
    if (rc_drv) begin
      rc_drv = 1'b0;
    end else begin
      rc_drv = 1'b1;
      repeat (8) tick();
      rc_drv = 1'b0;
    end
    wait_until(3, 1'b1, 30, n);
    check("pre_reset_present", 32'(n > 0), 32'd1);
    repeat (8) tick();
    #2;
    rst = 1'b1;
    #1;
    check("reset_async", 32'(all_outs()), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    base = rise_s_cnt;
    tick();
    check("no_pulse_after_release", 32'(peer_start_rise), 32'd0);
    wait_until(0, 1'b1, 20, n);
    check("reset_reacquire", n + 1, 6);
    check("reset_rise_same_cycle", 32'(peer_start_rise), 32'd1);
    pres_seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (peer_present) pres_seen = 1'b1;
    end
    check("reset_present_stays_low", 32'(pres_seen), 32'd0);
    check("reset_rise_cnt", 32'(rise_s_cnt - base), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
